stopwatch_ctrl: RTL and testbench

Stopwatch controller that consumes the single-cycle pulses produced by the button debouncers and turns them into a running/paused/lap-frozen BCD time value. It owns the state machine, a tick prescaler and a 4-digit BCD counter (SS.hh, 00.00–99.99). Its `disp` output feeds the seven-segment display driver directly.

---
 rtl/stopwatch_ctrl.sv | 175 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: turns debounced start/stop, lap and clear pulses into a
// running / paused / lap-frozen 4-digit BCD time value (SS.hh, 00.00-99.99).
// A prescaler divides sysclk down to hundredth-second ticks, and each tick
// advances the BCD count. disp drives the seven-segment display directly.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 1000000
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        btn_startstop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [15:0] disp,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    // Prescaler width is ceil(log2(TICK_DIV)); TICK_DIV is at least 2, so
    // the width is always at least one bit.
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RUN_LAP = 2'd2,
        PAUSE   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic [15:0]   count;
    logic [15:0]   count_inc;
    logic [15:0]   lap_reg;
    logic          do_clear;
    logic          do_capture;
    logic          advancing;
    logic          tick;
    logic          count_wrap;

    // The prescaler and count advance only while the pre-edge state is
    // RUN or RUN_LAP. This includes the edge that leaves for PAUSE.
    assign advancing = (state == RUN) || (state == RUN_LAP);
    assign tick      = advancing && (presc == PRESC_MAX);

    // Next state and one-cycle actions. Within a cycle, clear beats
    // startstop, and startstop beats lap. A button that is illegal in the
    // current state is ignored, so a lower-priority pulse may act instead.
    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        do_capture = 1'b0;
        case (state)
            IDLE: begin
                if (btn_startstop) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (btn_startstop) begin
                    state_next = PAUSE;
                end else if (btn_lap) begin
                    state_next = RUN_LAP;
                    do_capture = 1'b1;
                end
            end
            RUN_LAP: begin
                if (btn_startstop) begin
                    state_next = PAUSE;
                end else if (btn_lap) begin
                    state_next = RUN;
                end
            end
            PAUSE: begin
                if (btn_clear) begin
                    state_next = IDLE;
                    do_clear   = 1'b1;
                end else if (btn_startstop) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Prescaler. It holds its value in PAUSE, so a partial tick survives a
    // pause, and it is zeroed by clear.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            presc <= '0;
        end else if (do_clear) begin
            presc <= '0;
        end else if (advancing) begin
            if (presc == PRESC_MAX) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Next BCD value of the count. The carry ripples from h_ones upward,
    // and a carry out of s_tens means the count wraps from 99.99 to 00.00.
    always_comb begin
        logic carry;
        count_inc = count;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count[i*4 +: 4] >= 4'd9) begin
                    count_inc[i*4 +: 4] = 4'd0;
                end else begin
                    count_inc[i*4 +: 4] = count[i*4 +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        count_wrap = carry;
    end

    // Live BCD count.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            count <= '0;
        end else if (do_clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count_inc;
        end
    end

    // Sticky overflow flag. It is set when the count wraps past 99.99 and
    // is cleared only by reset or clear.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (do_clear) begin
            overflow <= 1'b0;
        end else if (tick && count_wrap) begin
            overflow <= 1'b1;
        end
    end

    // Lap snapshot. It takes the pre-edge count, so a tick on the capture
    // edge is not part of the frozen value.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            lap_reg <= '0;
        end else if (do_clear) begin
            lap_reg <= '0;
        end else if (do_capture) begin
            lap_reg <= count;
        end
    end

    // Status outputs are decoded from the state register only, so there is
    // no path from the button inputs to these outputs.
    assign running    = (state == RUN) || (state == RUN_LAP);
    assign lap_active = (state == RUN_LAP);
    assign disp       = (state == RUN_LAP) ? lap_reg : count;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with TICK_DIV = 4.
// Inputs change 1 time unit after each rising edge, and outputs are sampled
// at that same point, which is well away from the active edge.
module tb_stopwatch_ctrl;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_startstop = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_clear = 1'b0;
    logic [15:0] disp;
    logic        running;
    logic        lap_active;
    logic        overflow;

    int vectors = 0;
    int errors  = 0;

    logic [18:0] obs;
    assign obs = {disp, running, lap_active, overflow};

    stopwatch_ctrl #(.TICK_DIV(4)) dut (
        .sysclk        (sysclk),
        .reset         (reset),
        .btn_startstop (btn_startstop),
        .btn_lap       (btn_lap),
        .btn_clear     (btn_clear),
        .disp          (disp),
        .running       (running),
        .lap_active    (lap_active),
        .overflow      (overflow)
    );

    // 10-time-unit system clock.
    always #5 sysclk = ~sysclk;

    // Advance n rising edges, then settle 1 unit past the last edge.
    task automatic edges(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // One-cycle button pulses, each sampled on exactly one edge.
    task automatic pulse_ss();
        btn_startstop = 1'b1;
        edges(1);
        btn_startstop = 1'b0;
    endtask

    task automatic pulse_lap();
        btn_lap = 1'b1;
        edges(1);
        btn_lap = 1'b0;
    endtask

    task automatic pulse_clear();
        btn_clear = 1'b1;
        edges(1);
        btn_clear = 1'b0;
    endtask

    // Reset values, and lap/clear being ignored in IDLE.
    task automatic test_reset();
        reset = 1'b1;
        edges(2);
        reset = 1'b0;
        vectors++;
        if (obs !== {16'h0000, 3'b000}) begin
            errors++;
            $display("[TB] FAIL reset_values: got %h required %h", obs, {16'h0000, 3'b000});
        end
        edges(20);
        vectors++;
        if (obs !== {16'h0000, 3'b000}) begin
            errors++;
            $display("[TB] FAIL idle_20: got %h required %h", obs, {16'h0000, 3'b000});
        end
        pulse_lap();
        pulse_clear();
        btn_lap = 1'b1; btn_clear = 1'b1;
        edges(1);
        btn_lap = 1'b0; btn_clear = 1'b0;
        edges(8);
        vectors++;
        if (obs !== {16'h0000, 3'b000}) begin
            errors++;
            $display("[TB] FAIL idle_ignore: got %h required %h", obs, {16'h0000, 3'b000});
        end
    endtask

    // Tick timing, pause hold, and the prescaler keeping its partial count.
    task automatic test_start_pause();
        pulse_ss();                               // edge 0
        vectors++;
        if (obs !== {16'h0000, 3'b100}) begin
            errors++;
            $display("[TB] FAIL start_edge0: got %h required %h", obs, {16'h0000, 3'b100});
        end
        edges(3);                                 // edge 3
        vectors++;
        if (obs !== {16'h0000, 3'b100}) begin
            errors++;
            $display("[TB] FAIL before_tick1: got %h required %h", obs, {16'h0000, 3'b100});
        end
        edges(1);                                 // edge 4
        vectors++;
        if (obs !== {16'h0001, 3'b100}) begin
            errors++;
            $display("[TB] FAIL tick1_edge4: got %h required %h", obs, {16'h0001, 3'b100});
        end
        edges(4);                                 // edge 8
        vectors++;
        if (obs !== {16'h0002, 3'b100}) begin
            errors++;
            $display("[TB] FAIL tick2_edge8: got %h required %h", obs, {16'h0002, 3'b100});
        end
        edges(1);                                 // edge 9
        pulse_ss();                               // edge 10, prescaler goes to 2
        edges(20);
        vectors++;
        if (obs !== {16'h0002, 3'b000}) begin
            errors++;
            $display("[TB] FAIL pause_hold: got %h required %h", obs, {16'h0002, 3'b000});
        end
        pulse_lap();
        vectors++;
        if (obs !== {16'h0002, 3'b000}) begin
            errors++;
            $display("[TB] FAIL pause_lap_ignored: got %h required %h", obs, {16'h0002, 3'b000});
        end
        pulse_ss();                               // resume, prescaler is still 2
        edges(1);
        vectors++;
        if (obs !== {16'h0002, 3'b100}) begin
            errors++;
            $display("[TB] FAIL resume_partial: got %h required %h", obs, {16'h0002, 3'b100});
        end
        edges(1);
        vectors++;
        if (obs !== {16'h0003, 3'b100}) begin
            errors++;
            $display("[TB] FAIL resume_tick: got %h required %h", obs, {16'h0003, 3'b100});
        end
    endtask

    // Lap freeze, release, capture on a tick edge, and leaving RUN_LAP for PAUSE.
    task automatic test_lap();
        edges(8);                                 // live 0005, prescaler 0
        pulse_clear();                            // clear is ignored in RUN
        vectors++;
        if (obs !== {16'h0005, 3'b100}) begin
            errors++;
            $display("[TB] FAIL run_clear_ignored: got %h required %h", obs, {16'h0005, 3'b100});
        end
        edges(3);                                 // live 0006, prescaler 0
        edges(3);                                 // prescaler 3
        edges(1);                                 // live 0007, prescaler 0
        edges(4);                                 // live 0008
        pulse_lap();                              // snapshot 0008, prescaler 1
        vectors++;
        if (obs !== {16'h0008, 3'b110}) begin
            errors++;
            $display("[TB] FAIL lap_freeze: got %h required %h", obs, {16'h0008, 3'b110});
        end
        edges(3);                                 // live 0009
        vectors++;
        if (obs !== {16'h0008, 3'b110}) begin
            errors++;
            $display("[TB] FAIL lap_held: got %h required %h", obs, {16'h0008, 3'b110});
        end
        edges(12);                                // live 0012, prescaler 0
        pulse_lap();                              // release, prescaler 1
        vectors++;
        if (obs !== {16'h0012, 3'b100}) begin
            errors++;
            $display("[TB] FAIL lap_release: got %h required %h", obs, {16'h0012, 3'b100});
        end
        edges(2);                                 // prescaler 3
        pulse_lap();                              // tick edge: live 0013, snapshot 0012
        vectors++;
        if (obs !== {16'h0012, 3'b110}) begin
            errors++;
            $display("[TB] FAIL lap_on_tick: got %h required %h", obs, {16'h0012, 3'b110});
        end
        pulse_ss();                               // RUN_LAP to PAUSE
        vectors++;
        if (obs !== {16'h0013, 3'b000}) begin
            errors++;
            $display("[TB] FAIL runlap_pause: got %h required %h", obs, {16'h0013, 3'b000});
        end
    endtask

    // BCD carries, the 99.99 wrap with sticky overflow, and clear beating startstop.
    task automatic test_carries_clear();
        pulse_clear();
        vectors++;
        if (obs !== {16'h0000, 3'b000}) begin
            errors++;
            $display("[TB] FAIL clear_basic: got %h required %h", obs, {16'h0000, 3'b000});
        end
        pulse_ss();
        edges(36);
        vectors++;
        if (obs !== {16'h0009, 3'b100}) begin
            errors++;
            $display("[TB] FAIL count_0009: got %h required %h", obs, {16'h0009, 3'b100});
        end
        edges(4);
        vectors++;
        if (obs !== {16'h0010, 3'b100}) begin
            errors++;
            $display("[TB] FAIL carry_0010: got %h required %h", obs, {16'h0010, 3'b100});
        end
        edges(3956);
        vectors++;
        if (obs !== {16'h0999, 3'b100}) begin
            errors++;
            $display("[TB] FAIL count_0999: got %h required %h", obs, {16'h0999, 3'b100});
        end
        edges(4);
        vectors++;
        if (obs !== {16'h1000, 3'b100}) begin
            errors++;
            $display("[TB] FAIL carry_1000: got %h required %h", obs, {16'h1000, 3'b100});
        end
        edges(35996);
        vectors++;
        if (obs !== {16'h9999, 3'b100}) begin
            errors++;
            $display("[TB] FAIL count_9999: got %h required %h", obs, {16'h9999, 3'b100});
        end
        edges(4);
        vectors++;
        if (obs !== {16'h0000, 3'b101}) begin
            errors++;
            $display("[TB] FAIL wrap_overflow: got %h required %h", obs, {16'h0000, 3'b101});
        end
        edges(8);
        pulse_ss();                               // PAUSE at 0002, prescaler 1
        vectors++;
        if (obs !== {16'h0002, 3'b001}) begin
            errors++;
            $display("[TB] FAIL overflow_sticky: got %h required %h", obs, {16'h0002, 3'b001});
        end
        btn_clear = 1'b1; btn_startstop = 1'b1;
        edges(1);
        btn_clear = 1'b0; btn_startstop = 1'b0;
        vectors++;
        if (obs !== {16'h0000, 3'b000}) begin
            errors++;
            $display("[TB] FAIL clear_beats_ss: got %h required %h", obs, {16'h0000, 3'b000});
        end
        pulse_ss();                               // the prescaler must restart from 0
        edges(3);
        vectors++;
        if (obs !== {16'h0000, 3'b100}) begin
            errors++;
            $display("[TB] FAIL presc_cleared: got %h required %h", obs, {16'h0000, 3'b100});
        end
        edges(1);
        vectors++;
        if (obs !== {16'h0001, 3'b100}) begin
            errors++;
            $display("[TB] FAIL first_tick_after_clear: got %h required %h", obs, {16'h0001, 3'b100});
        end
    endtask

    // Reset while in RUN_LAP at 0037 overrides a simultaneous button pulse.
    task automatic test_reset_mid();
        edges(144);                               // live 0037
        pulse_lap();
        vectors++;
        if (obs !== {16'h0037, 3'b110}) begin
            errors++;
            $display("[TB] FAIL lap_0037: got %h required %h", obs, {16'h0037, 3'b110});
        end
        reset = 1'b1; btn_startstop = 1'b1;
        edges(1);
        reset = 1'b0; btn_startstop = 1'b0;
        vectors++;
        if (obs !== {16'h0000, 3'b000}) begin
            errors++;
            $display("[TB] FAIL reset_mid: got %h required %h", obs, {16'h0000, 3'b000});
        end
        edges(10);
        vectors++;
        if (obs !== {16'h0000, 3'b000}) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %h required %h", obs, {16'h0000, 3'b000});
        end
        pulse_ss();
        edges(4);
        vectors++;
        if (obs !== {16'h0001, 3'b100}) begin
            errors++;
            $display("[TB] FAIL restart_after_reset: got %h required %h", obs, {16'h0001, 3'b100});
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_start_pause();
        test_lap();
        test_carries_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
